// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector.
// Pattern, length and overlap mode are latched on cfg_load; din is shifted
// into a history register when din_valid is high. seq_detected is a
// registered one-cycle pulse on the edge that samples the final pattern bit.
// Optional feature macro: SEQ_DET_COUNT_EN -- when defined, match_count is a
// saturating count of detections; otherwise match_count is tied to 0.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_mode,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(2);

  logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_ovl_q, cfg_ovl_d;
  logic [MAX_LEN-1:0] history_q, history_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  // Configuration latch, history shift and match evaluation on the updated history.
  always_comb begin
    cfg_pat_d = cfg_pat_q;
    cfg_len_d = cfg_len_q;
    cfg_ovl_d = cfg_ovl_q;
    history_d = history_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    match     = 1'b0;
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(cfg_len_q));
    if (cfg_load) begin
      // Loading discards partial history, so no match can complete this edge.
      cfg_pat_d = pattern;
      cfg_len_d = (pat_len > MAX_LEN_L) ? MAX_LEN_L : pat_len;
      cfg_ovl_d = overlap_mode;
      history_d = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      history_d = {history_q[MAX_LEN-2:0], din};
      fill_d    = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;
      // Lengths 0 and 1 leave the detector disabled.
      match = (cfg_len_q >= MIN_LEN_L) && (fill_d >= cfg_len_q) &&
              (((history_d ^ cfg_pat_q) & len_mask) == '0);
      if (match) begin
        det_d = 1'b1;
        // Non-overlapping: the next match needs a full set of fresh bits.
        if (!cfg_ovl_q) fill_d = '0;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_pat_q <= '0;
      cfg_len_q <= '0;
      cfg_ovl_q <= 1'b0;
      history_q <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
    end else begin
      cfg_pat_q <= cfg_pat_d;
      cfg_len_q <= cfg_len_d;
      cfg_ovl_q <= cfg_ovl_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
    end
  end

  assign seq_detected = det_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating detection counter; holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: expected pulses are pushed to a queue as
// each cycle is driven and popped/compared once the registered output settles.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               overlap_mode = 1'b0;
  logic               seq_detected;
  logic [CNT_W-1:0]   match_count;

  int checks = 0;
  int errors = 0;
  int det_cnt = 0;   // detections the stimulus should have produced since reset
  bit exp_q[$];

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_mode(overlap_mode), .seq_detected(seq_detected),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_count();
    int c;
    c = (det_cnt > 255) ? 255 : det_cnt;
    return CNT_ON ? CNT_W'(c) : '0;
  endfunction

  // One clock with the given data inputs; outputs sampled 1 time unit after the edge.
  task automatic drive(input bit v, input bit d, input bit exp_det);
    exp_q.push_back(exp_det);
    if (exp_det) det_cnt++;
    din_valid = v; din = d; cfg_load = 1'b0;
    @(posedge clk); #1;
  endtask

  // Configuration cycle; din is held valid/1 to show it is ignored.
  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
    exp_q.push_back(1'b0);
    cfg_load = 1'b1; pattern = p; pat_len = l; overlap_mode = o;
    din_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; din_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit e;
    reset = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    det_cnt = 0;
    e = exp_q.pop_front();
    checks++;
    if (seq_detected !== e) begin errors++; $display("FAIL reset_det got=%0b exp=%0b", seq_detected, e); end
    checks++;
    if (match_count !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", match_count); end
  endtask

  task automatic test_basic();
    bit [4:0] s = 5'b10011;
    bit [4:0] x = 5'b00001;
    bit e;
    load(8'b0001_0011, 4'd5, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (seq_detected !== e) begin errors++; $display("FAIL basic_load got=%0b exp=%0b", seq_detected, e); end
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, s[i], x[i]);
      e = exp_q.pop_front();
      checks++;
      if (seq_detected !== e) begin errors++; $display("FAIL basic_bit%0d got=%0b exp=%0b", 4 - i, seq_detected, e); end
    end
    checks++;
    if (match_count !== exp_count()) begin errors++; $display("FAIL basic_cnt got=%0d exp=%0d", match_count, exp_count()); end
    drive(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (seq_detected !== e) begin errors++; $display("FAIL basic_pulse_end got=%0b exp=%0b", seq_detected, e); end
  endtask

  task automatic test_overlap();
    bit [6:0] s = 7'b1011011;
    bit [6:0] x;
    bit e;
    for (int m = 1; m >= 0; m--) begin
      x = (m == 1) ? 7'b0001001 : 7'b0001000;
      load(8'b0000_1011, 4'd4, m[0]);
      void'(exp_q.pop_front());
      for (int i = 6; i >= 0; i--) begin
        drive(1'b1, s[i], x[i]);
        e = exp_q.pop_front();
        checks++;
        if (seq_detected !== e) begin errors++; $display("FAIL overlap%0d_bit%0d got=%0b exp=%0b", m, 6 - i, seq_detected, e); end
      end
      checks++;
      if (match_count !== exp_count()) begin errors++; $display("FAIL overlap%0d_cnt got=%0d exp=%0d", m, match_count, exp_count()); end
    end
  endtask

  task automatic test_stall();
    bit [7:0] v = 8'b11100011;
    bit [7:0] s = 8'b10000011;
    bit [7:0] x = 8'b00000001;
    bit e;
    load(8'b0001_0011, 4'd5, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 7; i >= 0; i--) begin
      drive(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      checks++;
      if (seq_detected !== e) begin errors++; $display("FAIL stall_cyc%0d got=%0b exp=%0b", 7 - i, seq_detected, e); end
    end
    checks++;
    if (match_count !== exp_count()) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", match_count, exp_count()); end
  endtask

  task automatic test_interrupt();
    bit [3:0] p = 4'b1001;
    bit [4:0] s = 5'b10011;
    bit [4:0] x = 5'b00001;
    bit e;
    load(8'b0001_0011, 4'd5, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 3; i >= 0; i--) begin
      drive(1'b1, p[i], 1'b0);
      void'(exp_q.pop_front());
    end
    load(8'b0001_0011, 4'd5, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (seq_detected !== e) begin errors++; $display("FAIL intr_load got=%0b exp=%0b", seq_detected, e); end
    drive(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (seq_detected !== e) begin errors++; $display("FAIL intr_after got=%0b exp=%0b", seq_detected, e); end
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, s[i], x[i]);
      e = exp_q.pop_front();
      checks++;
      if (seq_detected !== e) begin errors++; $display("FAIL intr_fresh%0d got=%0b exp=%0b", 4 - i, seq_detected, e); end
    end
  endtask

  task automatic test_len_limits();
    bit [7:0] s = 8'hA5;
    bit e;
    int bad = 0;
    load(8'hA5, 4'd12, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, s[i], i == 0);
      e = exp_q.pop_front();
      checks++;
      if (seq_detected !== e) begin errors++; $display("FAIL clamp_bit%0d got=%0b exp=%0b", 7 - i, seq_detected, e); end
    end
    load(8'h00, 4'd0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'($urandom_range(1, 0)), 1'b0);
      e = exp_q.pop_front();
      if (seq_detected !== e) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL len0_pulses got=%0d exp=0", bad); end
  endtask

  task automatic test_saturation();
    bit e;
    int bad = 0;
    load(8'b0000_0011, 4'd2, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, i != 0);
      e = exp_q.pop_front();
      if (seq_detected !== e) bad++;
      if (CNT_ON == 1'b0 && match_count !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sat_stream got=%0d bad cycles exp=0", bad); end
    checks++;
    if (match_count !== exp_count()) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", match_count, exp_count()); end
    drive(1'b1, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    checks++;
    if (match_count !== exp_count()) begin errors++; $display("FAIL sat_hold got=%0d exp=%0d", match_count, exp_count()); end
  endtask

  task automatic test_reset_priority();
    bit e;
    reset = 1'b1; cfg_load = 1'b1; pattern = 8'b0000_0011; pat_len = 4'd2;
    overlap_mode = 1'b1; din_valid = 1'b1; din = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk); #1;
    reset = 1'b0; cfg_load = 1'b0;
    det_cnt = 0;
    e = exp_q.pop_front();
    checks++;
    if (seq_detected !== e) begin errors++; $display("FAIL rstpri_det got=%0b exp=%0b", seq_detected, e); end
    checks++;
    if (match_count !== '0) begin errors++; $display("FAIL rstpri_cnt got=%0d exp=0", match_count); end
    // Config was cleared, so an all-ones stream must not detect.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (seq_detected !== e) begin errors++; $display("FAIL rstpri_bit%0d got=%0b exp=%0b", i, seq_detected, e); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_overlap();
    test_stall();
    test_interrupt();
    test_len_limits();
    test_saturation();
    test_reset_priority();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_left got=%0d exp=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
